mac_accumulator: RTL and testbench

Sequential signed multiply-accumulate stage that forms an N-term dot product of A-bit operand pairs into a saturated B-bit result. It sits directly upstream of the enable register: `out` drives the register's `in`, and the one-cycle `out_valid` strobe drives its `en`, so the register captures exactly one finished result per dot product.

---
 rtl/mac_accumulator.sv | 107 ++++++++++
 tb/tb_mac_accumulator.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Signed N-term multiply-accumulate with per-step saturation; one out_valid strobe per dot product.
// state | meaning: IDLE waits for start | ACC accepts operand pairs | DONE presents result for one cycle
module mac_accumulator #(
    parameter int B = 18,
    parameter int A = 9,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [A-1:0] a_in,
    input  logic [A-1:0] w_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [B-1:0] out,
    output logic         out_valid,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);
    localparam logic [B-1:0] SMAX = {1'b0, {(B-1){1'b1}}};
    localparam logic [B-1:0] SMIN = {1'b1, {(B-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t state, state_nxt;

    logic [B-1:0]          acc;
    logic [CW-1:0]         cnt;
    logic signed [2*A-1:0] prod;
    logic [B:0]            prod_ext;
    logic [B:0]            sum;
    logic [B-1:0]          sum_sat;
    logic                  accept;
    logic                  last;

    always_comb begin
        prod     = $signed(a_in) * $signed(w_in);
        prod_ext = {{(B+1-2*A){prod[2*A-1]}}, prod};
        sum      = {acc[B-1], acc} + prod_ext;
        // B+1-bit sum overflowed the B-bit range when its top two bits disagree
        if (sum[B] != sum[B-1]) begin
            sum_sat = sum[B] ? SMIN : SMAX;
        end else begin
            sum_sat = sum[B-1:0];
        end
    end

    assign accept = (state == ACC) && in_valid;
    assign last   = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (accept && last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            out <= '0;
        end else begin
            if (state == IDLE && start) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                acc <= sum_sat;
                cnt <= cnt + CW'(1);
                if (last) begin
                    out <= sum_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: driver queues expected results, a monitor checks each out_valid strobe.
module tb_mac_accumulator;

    localparam int B = 18;
    localparam int A = 9;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [A-1:0] a_in;
    logic [A-1:0] w_in;
    logic         in_valid;
    logic         in_ready;
    logic [B-1:0] out;
    logic         out_valid;
    logic         busy;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int exp_val_q[$];
    int exp_cyc_q[$];

    mac_accumulator #(.B(B), .A(A), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .w_in      (w_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic run_dot(input int av[4], input int wv[4], input int stall_at,
                           input int stall_len, input int abort_after,
                           input bit pulse_start, input int expv);
        int ks;
        int stalls;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ks = cyc;
        chk("busy_acc", int'(busy), 1);
        chk("ready_acc", int'(in_ready), 1);
        stalls = (stall_at >= 0 && stall_at < N) ? stall_len : 0;
        if (abort_after < 0) begin
            exp_val_q.push_back(expv);
            exp_cyc_q.push_back(ks + N + stalls);
        end
        for (int i = 0; i < N; i++) begin
            if (i == abort_after) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_busy", int'(busy), 0);
                chk("abort_ready", int'(in_ready), 0);
                chk("abort_out", int'($signed(out)), 0);
                repeat (3) @(negedge clk);
                return;
            end
            if (i == stall_at) begin
                repeat (stall_len) begin
                    in_valid = 1'b0;
                    start    = 1'b0;
                    a_in     = A'(77);
                    w_in     = A'(77);
                    @(negedge clk);
                    chk("ready_stall", int'(in_ready), 1);
                end
            end
            in_valid = 1'b1;
            a_in     = A'(av[i]);
            w_in     = A'(wv[i]);
            start    = pulse_start && (i == 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("busy_done", int'(busy), 1);
        chk("ready_done", int'(in_ready), 0);
        @(negedge clk);
        chk("busy_idle", int'(busy), 0);
        chk("out_hold", int'($signed(out)), expv);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        a_in     = '0;
        w_in     = '0;
        fork
            begin
                forever begin
                    @(negedge clk);
                    if (out_valid) begin
                        chk("out_valid_expected", int'(exp_val_q.size() > 0), 1);
                        if (exp_val_q.size() > 0) begin
                            chk("out_value", int'($signed(out)), exp_val_q.pop_front());
                            chk("out_valid_cycle", cyc, exp_cyc_q.pop_front());
                        end
                    end
                end
            end
            begin
                repeat (2) @(negedge clk);
                chk("rst_out", int'(out), 0);
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_ready", int'(in_ready), 0);
                rst = 1'b0;
                @(negedge clk);

                run_dot('{1, 2, 3, 4}, '{5, 6, 7, 8}, -1, 0, -1, 1'b0, 70);
                run_dot('{-256, -256, -256, -256}, '{-256, -256, -256, -256}, -1, 0, -1, 1'b0, 131071);
                run_dot('{-256, -256, -256, 255}, '{255, 255, 255, 255}, -1, 0, -1, 1'b0, -66047);
                run_dot('{-3, 7, -1, 100}, '{4, -2, -5, 1}, -1, 0, -1, 1'b0, 79);
                run_dot('{1, 2, 3, 4}, '{5, 6, 7, 8}, 2, 2, -1, 1'b0, 70);

                in_valid = 1'b1;
                a_in     = A'(100);
                w_in     = A'(100);
                repeat (3) begin
                    @(negedge clk);
                    chk("idle_ready", int'(in_ready), 0);
                end
                run_dot('{1, 2, 3, 4}, '{5, 6, 7, 8}, -1, 0, -1, 1'b1, 70);

                run_dot('{9, 9, 9, 9}, '{9, 9, 9, 9}, -1, 0, 2, 1'b0, 0);
                run_dot('{1, 2, 3, 4}, '{5, 6, 7, 8}, -1, 0, -1, 1'b0, 70);
                run_dot('{-1, 1, -1, 1}, '{1, 1, 1, 1}, -1, 0, -1, 1'b0, 0);

                repeat (5) @(negedge clk);
            end
        join_any
        chk("pending_results", exp_val_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
